// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - video timing measurement, lock FSM and pixel recovery; optional frame CRC via VTRX_CRC_EN
module video_timing_rx #(
  parameter int CNT_W  = 12,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de,
  input  logic             hs,
  input  logic             vs,
  input  logic [23:0]      pixel,
  output logic             locked,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             pix_valid,
  output logic [23:0]      pix_out,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             timing_err,
  output logic [15:0]      frame_crc,
  output logic             crc_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  state_t           state;
  logic             armed;
  logic             de_s1, hs_s1, vs_s1, hs_s1_q, vs_s1_q;
  logic [23:0]      pix_s1;
  logic [CNT_W-1:0] h_cnt, da_cnt, v_cnt, va_cnt, h_tot_f, h_act_f;
  logic [CNT_W-1:0] cand_htot, cand_hact, cand_vt, cand_va;
  logic [CNT_W-1:0] lk_htot, lk_hact, lk_vt, lk_va;
  logic             pv2, fs2, err2;
  logic [23:0]      px2;
  logic [CNT_W-1:0] x2, y2;

  // Syncs are reduced to "active" flags so everything downstream is polarity-free
  logic             ls, fs, line_had_de, sat, line_bad, frame_bad, match, pix_ok;
  logic [CNT_W-1:0] line_len, da_base, va_fin, va_base, h_tot_fin, h_act_fin;

  assign ls          = hs_s1 & ~hs_s1_q;
  assign fs          = vs_s1 & ~vs_s1_q;
  assign line_len    = h_cnt + CNT_ONE;
  assign line_had_de = (da_cnt != '0);
  assign da_base     = ls ? '0 : da_cnt;
  assign va_fin      = va_cnt + ((ls && line_had_de) ? CNT_ONE : '0);
  assign va_base     = fs ? '0 : va_fin;
  assign h_tot_fin   = ls ? line_len : h_tot_f;
  assign h_act_fin   = (ls && line_had_de) ? da_cnt : h_act_f;
  // A sync edge arriving at the saturated count is still a valid boundary
  assign sat         = ((h_cnt == CNT_MAX) && !ls) || ((v_cnt == CNT_MAX) && !fs);
  assign line_bad    = ls && ((line_len != lk_htot) || (line_had_de && (da_cnt != lk_hact)));
  assign frame_bad   = fs && ((v_cnt != lk_vt) || (va_fin != lk_va));
  assign match       = (h_tot_fin == cand_htot) && (h_act_fin == cand_hact) &&
                       (v_cnt == cand_vt) && (va_fin == cand_va);
  assign pix_ok      = de_s1 && (state == LOCKED) && !sat && !line_bad && !frame_bad;

  // Input register stage plus one-cycle history of the sync flags for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1 <= 1'b0; hs_s1 <= 1'b0; vs_s1 <= 1'b0; pix_s1 <= '0;
      hs_s1_q <= 1'b0; vs_s1_q <= 1'b0;
    end else begin
      de_s1   <= de;
      hs_s1   <= (hs == HS_POL);
      vs_s1   <= (vs == VS_POL);
      pix_s1  <= pixel;
      hs_s1_q <= hs_s1;
      vs_s1_q <= vs_s1;
    end
  end

  // Geometry counters; the hs/vs-coincident line is counted as line 0 of the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0; da_cnt <= '0; v_cnt <= '0; va_cnt <= '0; h_tot_f <= '0; h_act_f <= '0;
    end else begin
      h_cnt   <= ls ? '0 : ((h_cnt == CNT_MAX) ? h_cnt : h_cnt + CNT_ONE);
      da_cnt  <= da_base + (de_s1 ? CNT_ONE : '0);
      va_cnt  <= va_base;
      v_cnt   <= fs ? (ls ? CNT_ONE : '0)
                    : ((ls && (v_cnt != CNT_MAX)) ? v_cnt + CNT_ONE : v_cnt);
      h_tot_f <= h_tot_fin;
      h_act_f <= h_act_fin;
    end
  end

  // Lock FSM; armed=0 means the current frame is partial and must be skipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH; armed <= 1'b0; err2 <= 1'b0;
      cand_htot <= '0; cand_hact <= '0; cand_vt <= '0; cand_va <= '0;
      lk_htot <= '0; lk_hact <= '0; lk_vt <= '0; lk_va <= '0;
    end else begin
      err2 <= 1'b0;
      if (sat) begin
        if (state == LOCKED) err2 <= 1'b1;
        state <= SEARCH;
      end else begin
        case (state)
          SEARCH: if (fs) begin
            state <= MEASURE; armed <= 1'b1;
          end
          MEASURE: if (fs) begin
            if (armed) begin
              cand_htot <= h_tot_fin; cand_hact <= h_act_fin;
              cand_vt <= v_cnt; cand_va <= va_fin;
              state <= VERIFY;
            end else begin
              armed <= 1'b1;
            end
          end
          VERIFY: if (fs) begin
            if (match) begin
              lk_htot <= cand_htot; lk_hact <= cand_hact; lk_vt <= cand_vt; lk_va <= cand_va;
              state <= LOCKED;
            end else begin
              state <= MEASURE; armed <= 1'b1;
            end
          end
          LOCKED: if (line_bad || frame_bad) begin
            err2 <= 1'b1; state <= MEASURE; armed <= fs;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Pixel stage: coordinates captured alongside the pixel they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv2 <= 1'b0; px2 <= '0; x2 <= '0; y2 <= '0; fs2 <= 1'b0;
    end else begin
      pv2 <= pix_ok;
      px2 <= pix_s1;
      x2  <= da_base;
      y2  <= va_base;
      fs2 <= pix_ok && (da_base == '0) && (va_base == '0);
    end
  end

  // Output registers; geometry only follows the locked values while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0; timing_err <= 1'b0; pix_valid <= 1'b0; pix_out <= '0;
      x <= '0; y <= '0; frame_start <= 1'b0;
      h_total <= '0; h_active <= '0; v_total <= '0; v_active <= '0;
    end else begin
      locked      <= (state == LOCKED);
      timing_err  <= err2;
      pix_valid   <= pv2;
      pix_out     <= px2;
      x           <= x2;
      y           <= y2;
      frame_start <= fs2;
      if (state == LOCKED) begin
        h_total <= lk_htot; h_active <= lk_hact; v_total <= lk_vt; v_active <= lk_va;
      end
    end
  end

`ifdef VTRX_CRC_EN
  function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  logic [15:0] crc_run;
  logic        crc_have;

  // Running CRC per frame, published at the next frame's first pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run <= 16'hFFFF; crc_have <= 1'b0; frame_crc <= '0; crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if (pv2) begin
        if (fs2) begin
          crc_valid <= crc_have;
          if (crc_have) frame_crc <= crc_run;
          crc_run  <= crc24(16'hFFFF, px2);
          crc_have <= 1'b1;
        end else begin
          crc_run <= crc24(crc_run, px2);
        end
      end else if (state != LOCKED) begin
        crc_have <= 1'b0;
      end
    end
  end
`else
  assign frame_crc = 16'h0000;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_rx.sv
// tb/tb_video_timing_rx.sv - directed scoreboard bench for video_timing_rx
module tb_video_timing_rx;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             de = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [23:0]      pixel = '0;
  logic             locked, pix_valid, frame_start, timing_err, crc_valid;
  logic [CNT_W-1:0] h_total, h_active, v_total, v_active, x, y;
  logic [23:0]      pix_out;
  logic [15:0]      frame_crc;

  video_timing_rx #(.CNT_W(CNT_W), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hs(hs), .vs(vs), .pixel(pixel),
    .locked(locked), .h_total(h_total), .h_active(h_active), .v_total(v_total),
    .v_active(v_active), .pix_valid(pix_valid), .pix_out(pix_out), .x(x), .y(y),
    .frame_start(frame_start), .timing_err(timing_err), .frame_crc(frame_crc),
    .crc_valid(crc_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] pix;
    int          ex;
    int          ey;
    int          ecyc;
    bit          efs;
  } item_t;

  item_t sb[$];
  int n_checks = 0, n_pass = 0, n_fail = 0;
  int fs_pos = 0, frame_no = 0, lock_frame = 0;
  int pv_count = 0, fs_count = 0, err_cycles = 0;
  bit locked_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef VTRX_CRC_EN
  logic [15:0] model_crc = 16'hFFFF;
  bit          model_have = 1'b0;

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else r = r << 1;
    end
    return r;
  endfunction
`endif

  // Output monitor: pops scoreboard entries on pix_valid and tracks lock/err events
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      locked_q = 1'b0;
    end else begin
      if (sb.size() > 0 && cyc > sb[0].ecyc) begin
        check("pix_missing", cyc, sb[0].ecyc);
        it = sb.pop_front();
      end
      if (pix_valid) begin
        pv_count++;
        if (sb.size() == 0) begin
          check("pix_unexpected", pix_valid, 1'b0);
        end else begin
          it = sb.pop_front();
          check("pix_out", pix_out, it.pix);
          check("x", x, it.ex);
          check("y", y, it.ey);
          check("pix_latency", cyc, it.ecyc);
          check("frame_start", frame_start, it.efs);
`ifdef VTRX_CRC_EN
          if (it.efs) begin
            check("crc_valid", crc_valid, model_have);
            if (model_have) check("frame_crc", frame_crc, model_crc);
            model_crc  = crc_model(16'hFFFF, it.pix);
            model_have = 1'b1;
          end else begin
            check("crc_valid_idle", crc_valid, 1'b0);
            model_crc = crc_model(model_crc, it.pix);
          end
`else
          check("crc_tied_zero", {crc_valid, frame_crc}, 17'h0);
`endif
        end
      end else begin
        check("frame_start_no_pix", frame_start, 1'b0);
      end
      if (frame_start) fs_count++;
      if (timing_err) err_cycles++;
      if (locked && !locked_q) begin
        check("lock_latency", cyc, fs_pos + 2);
        lock_frame = frame_no;
      end
      locked_q = locked;
`ifdef VTRX_CRC_EN
      if (!locked) model_have = 1'b0;
`endif
    end
  end

  // One line: h_total 20 (19 if short), hs low cols 0-1, vs low lines 0-1, de lines 3-8 cols 4-15
  task automatic send_line(input int l, input bit expect_pix, input bit short_line);
    int          len;
    bit          d;
    logic [23:0] p;
    len = short_line ? 19 : 20;
    for (int c = 0; c < len; c++) begin
      d = (l >= 3 && l <= 8 && c >= 4 && c < 16);
      p = 24'($urandom());
      @(negedge clk);
      if (l == 0 && c == 0) fs_pos = cyc + 1;
      de = d; hs = (c < 2) ? 1'b0 : 1'b1; vs = (l < 2) ? 1'b0 : 1'b1; pixel = p;
      if (d && expect_pix) sb.push_back('{p, c - 4, l - 3, cyc + 3, (l == 3 && c == 4)});
    end
  endtask

  task automatic send_frame(input bit expect_pix, input int short_at);
    frame_no++;
    for (int l = 0; l < 10; l++)
      send_line(l, expect_pix && (short_at < 0 || l <= short_at), l == short_at);
  endtask

  task automatic check_geometry(input string tag);
    check({tag, "_h_total"}, h_total, 20);
    check({tag, "_h_active"}, h_active, 12);
    check({tag, "_v_total"}, v_total, 10);
    check({tag, "_v_active"}, v_active, 6);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", |{locked, h_total, h_active, v_total, v_active, pix_valid, pix_out,
                             x, y, frame_start, timing_err, frame_crc, crc_valid}, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int l = 5; l < 10; l++) send_line(l, 1'b0, 1'b0);

    send_frame(1'b0, -1);
    send_frame(1'b0, -1);
    send_frame(1'b1, -1);
    check("lock_frame_initial", lock_frame, 3);
    check("locked_initial", locked, 1'b1);
    check_geometry("initial");

    pv_count = 0; fs_count = 0;
    send_frame(1'b1, -1);
    check("frame_pix_count", pv_count, 72);
    check("frame_start_count", fs_count, 1);
    check("no_err_when_stable", err_cycles, 0);

    send_frame(1'b1, 5);
    check("short_line_err", err_cycles, 1);
    check("short_line_unlock", locked, 1'b0);
    send_frame(1'b0, -1);
    send_frame(1'b0, -1);
    send_frame(1'b1, -1);
    check("lock_frame_after_err", lock_frame, 8);
    check("err_after_relock", err_cycles, 1);

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      de = 1'b0; hs = 1'b1; vs = 1'b1;
    end
    check("sat_err", err_cycles, 2);
    check("sat_unlock", locked, 1'b0);
    check("sat_geometry_hold", h_total, 20);
    send_frame(1'b0, -1);
    send_frame(1'b0, -1);
    send_frame(1'b1, -1);
    check("lock_frame_after_sat", lock_frame, 11);

    frame_no++;
    send_line(0, 1'b0, 1'b0);
    send_line(1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midframe_reset_outputs", |{locked, h_total, h_active, v_total, v_active, pix_valid,
                                      pix_out, x, y, frame_start, timing_err, frame_crc,
                                      crc_valid}, 1'b0);
    send_line(2, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int l = 3; l < 10; l++) send_line(l, 1'b0, 1'b0);
    send_frame(1'b0, -1);
    send_frame(1'b0, -1);
    send_frame(1'b1, -1);
    check("lock_frame_after_reset", lock_frame, 15);
    check_geometry("relock");
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
